// File: rtl/memory_pkg.sv
// Shared types for the memory-stage data-bus initiator: access size, dbus request/response
// records and the transaction FSM state encoding.
package memory_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_type_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus channel between the memory-stage initiator (master) and the memory system (slave).
interface mem_access_unit_if;
  import memory_pkg::*;

  dbus_req_t  req;
  dbus_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);

endinterface

// File: rtl/store_format.sv
// Maps access size, byte offset and store source into dbus size code, byte strobe and
// lane-replicated write data.
module store_format
  import memory_pkg::*;
(
  input  mem_type_t   mem_type,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [2:0]  size,
  output logic [3:0]  strobe,
  output logic [31:0] data
);

  always_comb begin
    size   = 3'd2;
    strobe = 4'b1111;
    data   = wdata;
    case (mem_type)
      MEM_B: begin
        size   = 3'd0;
        strobe = 4'b0001 << offset;
        data   = {4{wdata[7:0]}};
      end
      MEM_H: begin
        size   = 3'd1;
        strobe = offset[1] ? 4'b1100 : 4'b0011;
        data   = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage data-bus initiator: issues one dbus transaction per load/store, holds it to
// completion, stalls the front pipe meanwhile and returns the raw read word to writeback.
//
//  state | meaning
//  IDLE  | no transaction; a new request is presented combinationally
//  REQ   | request presented, waiting for addr_ok (fields frozen in req_q)
//  WAIT  | request accepted, waiting for data_ok
//  DONE  | response received, holding until writeback takes it
module mem_access_unit
  import memory_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  mem_type_t         in_mem_type,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_wdata,
  input  logic              advance,
  input  logic              flush,
  mem_access_unit_if.master dbus,
  output logic [31:0]       rd_out,
  output logic              stall,
  output logic              misalign
);

  mau_state_t  state_q, state_d;
  logic        discard_q, discard_d;
  dbus_req_t   req_q, req_d, new_req, req_out;
  logic [31:0] rdata_q, rdata_d;
  logic        access, need, finish, is_load, addr_ok, data_ok, flush_idle;
  logic [2:0]  fmt_size;
  logic [3:0]  fmt_strobe;
  logic [31:0] fmt_data;

  assign addr_ok = dbus.resp.addr_ok;
  assign data_ok = dbus.resp.data_ok;

  assign access   = in_valid & (in_memread | in_memwrite);
  assign misalign = access & (((in_mem_type == MEM_H) & in_addr[0]) |
                              ((in_mem_type == MEM_W) & (in_addr[1:0] != 2'b00)));
  assign need     = access & ~misalign;

  store_format u_store_format (
    .mem_type (in_mem_type),
    .offset   (in_addr[1:0]),
    .wdata    (in_wdata),
    .size     (fmt_size),
    .strobe   (fmt_strobe),
    .data     (fmt_data)
  );

  always_comb begin
    new_req.valid  = 1'b1;
    new_req.addr   = in_addr;
    new_req.size   = fmt_size;
    new_req.strobe = in_memwrite ? fmt_strobe : 4'b0000;
    new_req.data   = in_memwrite ? fmt_data : 32'h0;
  end

  // Loads are recognised by an all-zero strobe once the request has been captured.
  assign is_load = (state_q == ST_IDLE) ? (in_memread & ~in_memwrite) : (req_q.strobe == 4'b0000);

  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    req_d         = req_q;
    rdata_d       = rdata_q;
    finish        = 1'b0;
    req_out       = req_q;
    req_out.valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (need && !flush) begin
          req_out = new_req;
          req_d   = new_req;
          if (addr_ok && data_ok) begin
            finish  = 1'b1;
            state_d = advance ? ST_IDLE : ST_DONE;
          end else begin
            state_d = addr_ok ? ST_WAIT : ST_REQ;
          end
        end
      end
      ST_REQ: begin
        req_out = req_q;
        if (addr_ok && data_ok) begin
          finish = 1'b1;
        end else begin
          state_d = addr_ok ? ST_WAIT : ST_REQ;
          if (flush) discard_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (data_ok) finish = 1'b1;
        else if (flush) discard_d = 1'b1;
      end
      ST_DONE: begin
        if (advance || flush) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // DONE only exists to hold a result writeback has not taken yet; skip it when it already has.
    if (finish && state_q != ST_IDLE) begin
      discard_d = 1'b0;
      state_d   = (discard_q || flush || advance) ? ST_IDLE : ST_DONE;
    end
    if (finish && !discard_q && !flush && is_load) rdata_d = dbus.resp.data;
    if (reset) req_out.valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      discard_q <= 1'b0;
      rdata_q   <= 32'h0;
      req_q     <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      rdata_q   <= rdata_d;
      req_q     <= req_d;
    end
  end

  assign dbus.req = req_out;

  // A flush seen in IDLE kills the instruction before anything is issued, so it must not stall.
  assign flush_idle = flush & (state_q == ST_IDLE);
  assign stall = ~reset & (discard_q |
                 (need & ~flush_idle & (state_q != ST_DONE) &
                  ~(data_ok & ((state_q != ST_IDLE) | addr_ok))));

  assign rd_out = (data_ok & ~discard_q) ? dbus.resp.data : rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of IDLE-state request vectors plus
// hand-written multi-cycle sequences for latency, load hold, flush and reset.
module tb_mem_access_unit;
  import memory_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_memread, in_memwrite;
  mem_type_t   in_mem_type;
  logic [31:0] in_addr, in_wdata;
  logic        advance, flush;
  logic [31:0] rd_out;
  logic        stall, misalign;

  int total = 0;
  int bad   = 0;

  mem_access_unit_if dbus ();

  mem_access_unit dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_memread  (in_memread),
    .in_memwrite (in_memwrite),
    .in_mem_type (in_mem_type),
    .in_addr     (in_addr),
    .in_wdata    (in_wdata),
    .advance     (advance),
    .flush       (flush),
    .dbus        (dbus.master),
    .rd_out      (rd_out),
    .stall       (stall),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && advance && stall) begin
      bad++;
      $display("FAIL advance_while_stall: advance=1 stall=1 at %0t", $time);
    end
  end

  typedef struct {
    string       name;
    logic        v, rd, wr, fl;
    mem_type_t   mt;
    logic [31:0] addr, wdata;
    logic        e_valid;
    logic [2:0]  e_size;
    logic [3:0]  e_strb;
    logic [31:0] e_data;
    logic        e_mis, e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic v, logic rd, logic wr, logic fl, mem_type_t mt,
                              logic [31:0] addr, logic [31:0] wdata, logic e_valid, logic [2:0] e_size,
                              logic [3:0] e_strb, logic [31:0] e_data, logic e_mis, logic e_stall);
    vec_t r;
    r.name = name; r.v = v; r.rd = rd; r.wr = wr; r.fl = fl; r.mt = mt;
    r.addr = addr; r.wdata = wdata; r.e_valid = e_valid; r.e_size = e_size;
    r.e_strb = e_strb; r.e_data = e_data; r.e_mis = e_mis; r.e_stall = e_stall;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic clear_in;
    in_valid = 1'b0; in_memread = 1'b0; in_memwrite = 1'b0; in_mem_type = MEM_W;
    in_addr = 32'h0; in_wdata = 32'h0; advance = 1'b0; flush = 1'b0;
    dbus.resp = '0;
  endtask

  task automatic rst_pulse;
    clear_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drive(input logic rd, input logic wr, input mem_type_t mt,
                       input logic [31:0] addr, input logic [31:0] wdata);
    in_valid = 1'b1; in_memread = rd; in_memwrite = wr; in_mem_type = mt;
    in_addr = addr; in_wdata = wdata;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk("reset_valid", {31'h0, dbus.req.valid}, 32'h0);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    chk("reset_rd_out", rd_out, 32'h0);
    chk("reset_misalign", {31'h0, misalign}, 32'h0);

    vecs.push_back(mk("sw_word",   1,0,1,0, MEM_W, 32'h8000_0004, 32'hDEAD_BEEF, 1, 3'd2, 4'b1111, 32'hDEAD_BEEF, 0, 1));
    vecs.push_back(mk("sb_off3",   1,0,1,0, MEM_B, 32'h8000_0003, 32'h0000_00A5, 1, 3'd0, 4'b1000, 32'hA5A5_A5A5, 0, 1));
    vecs.push_back(mk("sh_off2",   1,0,1,0, MEM_H, 32'h8000_0002, 32'h0000_1234, 1, 3'd1, 4'b1100, 32'h1234_1234, 0, 1));
    vecs.push_back(mk("sb_off0",   1,0,1,0, MEM_B, 32'h0000_1000, 32'h1234_5678, 1, 3'd0, 4'b0001, 32'h7878_7878, 0, 1));
    vecs.push_back(mk("sb_off1",   1,0,1,0, MEM_B, 32'h0000_1001, 32'h1234_5678, 1, 3'd0, 4'b0010, 32'h7878_7878, 0, 1));
    vecs.push_back(mk("sh_off0",   1,0,1,0, MEM_H, 32'h0000_1000, 32'hABCD_9876, 1, 3'd1, 4'b0011, 32'h9876_9876, 0, 1));
    vecs.push_back(mk("lw",        1,1,0,0, MEM_W, 32'h0000_1000, 32'hFFFF_FFFF, 1, 3'd2, 4'b0000, 32'h0,         0, 1));
    vecs.push_back(mk("lb_off3",   1,1,0,0, MEM_B, 32'h0000_1003, 32'hFFFF_FFFF, 1, 3'd0, 4'b0000, 32'h0,         0, 1));
    vecs.push_back(mk("lh_off2",   1,1,0,0, MEM_H, 32'h0000_1002, 32'h0,         1, 3'd1, 4'b0000, 32'h0,         0, 1));
    vecs.push_back(mk("lh_mis",    1,1,0,0, MEM_H, 32'h0000_1001, 32'h0,         0, 3'd0, 4'b0000, 32'h0,         1, 0));
    vecs.push_back(mk("lw_mis",    1,1,0,0, MEM_W, 32'h0000_1002, 32'h0,         0, 3'd0, 4'b0000, 32'h0,         1, 0));
    vecs.push_back(mk("sw_mis",    1,0,1,0, MEM_W, 32'h0000_1001, 32'h1111_1111, 0, 3'd0, 4'b0000, 32'h0,         1, 0));
    vecs.push_back(mk("not_valid", 0,0,1,0, MEM_W, 32'h0000_1000, 32'h1111_1111, 0, 3'd0, 4'b0000, 32'h0,         0, 0));
    vecs.push_back(mk("flush_idle",1,0,1,1, MEM_W, 32'h0000_1000, 32'h1111_1111, 0, 3'd0, 4'b0000, 32'h0,         0, 0));

    foreach (vecs[i]) begin
      rst_pulse();
      in_valid = vecs[i].v; in_memread = vecs[i].rd; in_memwrite = vecs[i].wr; flush = vecs[i].fl;
      in_mem_type = vecs[i].mt; in_addr = vecs[i].addr; in_wdata = vecs[i].wdata;
      settle();
      chk({vecs[i].name, "_valid"}, {31'h0, dbus.req.valid}, {31'h0, vecs[i].e_valid});
      chk({vecs[i].name, "_misalign"}, {31'h0, misalign}, {31'h0, vecs[i].e_mis});
      chk({vecs[i].name, "_stall"}, {31'h0, stall}, {31'h0, vecs[i].e_stall});
      if (vecs[i].e_valid) begin
        chk({vecs[i].name, "_addr"}, dbus.req.addr, vecs[i].addr);
        chk({vecs[i].name, "_size"}, {29'h0, dbus.req.size}, {29'h0, vecs[i].e_size});
        chk({vecs[i].name, "_strobe"}, {28'h0, dbus.req.strobe}, {28'h0, vecs[i].e_strb});
        chk({vecs[i].name, "_data"}, dbus.req.data, vecs[i].e_data);
      end
      tick();
    end

    // SW with addr_ok at cycle 2, data_ok at cycle 4
    rst_pulse();
    drive(0, 1, MEM_W, 32'h8000_0004, 32'hDEAD_BEEF);
    for (int c = 0; c < 5; c++) begin
      dbus.resp.addr_ok = (c == 2);
      dbus.resp.data_ok = (c == 4);
      advance = (c == 4);
      settle();
      chk($sformatf("sw_lat_stall_c%0d", c), {31'h0, stall}, (c < 4) ? 32'h1 : 32'h0);
      chk($sformatf("sw_lat_valid_c%0d", c), {31'h0, dbus.req.valid}, (c <= 2) ? 32'h1 : 32'h0);
      if (c <= 2) begin
        chk($sformatf("sw_lat_strobe_c%0d", c), {28'h0, dbus.req.strobe}, 32'hF);
        chk($sformatf("sw_lat_data_c%0d", c), dbus.req.data, 32'hDEAD_BEEF);
        chk($sformatf("sw_lat_addr_c%0d", c), dbus.req.addr, 32'h8000_0004);
      end
      tick();
    end
    clear_in();
    settle();
    chk("sw_lat_idle_valid", {31'h0, dbus.req.valid}, 32'h0);
    chk("sw_lat_idle_stall", {31'h0, stall}, 32'h0);

    // LW completing in the first cycle
    tick();
    drive(1, 0, MEM_W, 32'h0000_0100, 32'h0);
    dbus.resp.addr_ok = 1'b1; dbus.resp.data_ok = 1'b1; dbus.resp.data = 32'hCAFE_F00D;
    advance = 1'b1;
    settle();
    chk("lw0_stall", {31'h0, stall}, 32'h0);
    chk("lw0_rd_out", rd_out, 32'hCAFE_F00D);
    chk("lw0_valid", {31'h0, dbus.req.valid}, 32'h1);
    chk("lw0_strobe", {28'h0, dbus.req.strobe}, 32'h0);
    tick();
    clear_in();
    settle();
    chk("lw0_latched", rd_out, 32'hCAFE_F00D);

    // LW completing without advance: result held in DONE
    tick();
    drive(1, 0, MEM_W, 32'h0000_0104, 32'h0);
    dbus.resp.addr_ok = 1'b1;
    settle();
    chk("lw_hold_c0_stall", {31'h0, stall}, 32'h1);
    tick();
    dbus.resp.addr_ok = 1'b0; dbus.resp.data_ok = 1'b1; dbus.resp.data = 32'h1111_2222;
    settle();
    chk("lw_hold_c1_stall", {31'h0, stall}, 32'h0);
    chk("lw_hold_c1_bypass", rd_out, 32'h1111_2222);
    tick();
    dbus.resp.data_ok = 1'b0; dbus.resp.data = 32'h0;
    settle();
    chk("lw_hold_done_stall", {31'h0, stall}, 32'h0);
    chk("lw_hold_done_valid", {31'h0, dbus.req.valid}, 32'h0);
    chk("lw_hold_done_rd_out", rd_out, 32'h1111_2222);
    advance = 1'b1;
    tick();
    clear_in();

    // LW flushed in WAIT, followed by a SW
    drive(1, 0, MEM_W, 32'h0000_0200, 32'h0);
    tick();
    dbus.resp.addr_ok = 1'b1;
    tick();
    dbus.resp.addr_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(0, 1, MEM_W, 32'h0000_2000, 32'h0000_0055);
    settle();
    chk("flush_c3_stall", {31'h0, stall}, 32'h1);
    chk("flush_c3_valid", {31'h0, dbus.req.valid}, 32'h0);
    tick();
    dbus.resp.data_ok = 1'b1; dbus.resp.data = 32'h9999_9999;
    settle();
    chk("flush_c4_stall", {31'h0, stall}, 32'h1);
    chk("flush_c4_rd_out", rd_out, 32'h1111_2222);
    chk("flush_c4_valid", {31'h0, dbus.req.valid}, 32'h0);
    tick();
    dbus.resp.data_ok = 1'b0; dbus.resp.data = 32'h0;
    settle();
    chk("flush_sw_valid", {31'h0, dbus.req.valid}, 32'h1);
    chk("flush_sw_addr", dbus.req.addr, 32'h0000_2000);
    chk("flush_sw_strobe", {28'h0, dbus.req.strobe}, 32'hF);
    chk("flush_sw_data", dbus.req.data, 32'h0000_0055);
    chk("flush_sw_stall", {31'h0, stall}, 32'h1);
    dbus.resp.addr_ok = 1'b1; dbus.resp.data_ok = 1'b1; dbus.resp.data = 32'h7777_7777;
    advance = 1'b1;
    tick();
    clear_in();
    settle();
    chk("flush_rd_kept", rd_out, 32'h1111_2222);

    // Reset while in REQ
    tick();
    drive(0, 1, MEM_W, 32'h0000_0300, 32'h1234_5678);
    tick();
    settle();
    chk("rst_req_valid_before", {31'h0, dbus.req.valid}, 32'h1);
    clear_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("rst_req_valid", {31'h0, dbus.req.valid}, 32'h0);
    chk("rst_req_stall", {31'h0, stall}, 32'h0);
    chk("rst_req_rd_out", rd_out, 32'h0);
    drive(0, 1, MEM_B, 32'h0000_0401, 32'h0000_003C);
    #1;
    chk("rst_idle_valid", {31'h0, dbus.req.valid}, 32'h1);
    chk("rst_idle_addr", dbus.req.addr, 32'h0000_0401);
    chk("rst_idle_strobe", {28'h0, dbus.req.strobe}, 32'h2);
    chk("rst_idle_data", dbus.req.data, 32'h3C3C_3C3C);
    tick();
    clear_in();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
